// File: rtl/arm_pipe_pkg.sv
// rtl/arm_pipe_pkg.sv - shared LEGv8 pipeline constants and shadow entry type
package arm_pipe_pkg;
  localparam int DEF_REG_ADDR_W = 5;
  localparam int DEF_ZERO_REG   = 31;
  localparam int FWD_REGFILE    = 0;

  typedef struct packed {
    logic                      valid;
    logic [DEF_REG_ADDR_W-1:0] rd;
    logic                      load;
  } shadow_entry_t;
endpackage

// File: rtl/fwd_match.sv
// rtl/fwd_match.sv - youngest-match priority encoder over N producer positions
module fwd_match #(
  parameter int W        = 5,
  parameter int N        = 2,
  parameter int ZERO_REG = 31,
  parameter int SEL_W    = $clog2(N+1)
) (
  input  logic [N-1:0]     valid,
  input  logic [N*W-1:0]   rd,
  input  logic [N-1:0]     load,
  input  logic [W-1:0]     key,
  output logic [SEL_W-1:0] sel,
  output logic             sel_load
);
  // sel is position+1 of the lowest-index (youngest) match, 0 when none
  always_comb begin
    sel      = '0;
    sel_load = 1'b0;
    for (int i = N-1; i >= 0; i--) begin
      if (valid[i] && (rd[i*W +: W] == key)) begin
        sel      = SEL_W'(i+1);
        sel_load = load[i];
      end
    end
    if (key == W'(ZERO_REG)) begin
      sel      = '0;
      sel_load = 1'b0;
    end
  end
endmodule

// File: rtl/hazard_forward_unit.sv
// rtl/hazard_forward_unit.sv - shadow-pipeline forwarding selects, load-use stall and stall counter
module hazard_forward_unit
  import arm_pipe_pkg::*;
#(
  parameter int REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int ZERO_REG   = DEF_ZERO_REG,
  parameter int NUM_SRC    = 2,
  parameter int DEPTH      = 2,
  parameter int LOAD_LAT   = 1,
  parameter int SEL_W      = $clog2(DEPTH+1)
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [REG_ADDR_W-1:0]         ex_rd,
  input  logic                          ex_regwrite,
  input  logic                          ex_memread,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] ex_src,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] id_src,
  input  logic [NUM_SRC-1:0]            id_src_used,
  input  logic                          hold,
  input  logic                          flush,
  output logic [NUM_SRC*SEL_W-1:0]      fwd_sel,
  output logic                          stall,
  output logic [15:0]                   stall_count
);
  // bit k-1 / slice k-1 of each vector is shadow entry k
  logic [DEPTH-1:0]            sh_valid, sh_load;
  logic [DEPTH*REG_ADDR_W-1:0] sh_rd;
  logic                        ex_valid;
  logic [DEPTH-1:0]            st_valid, st_load;
  logic [DEPTH*REG_ADDR_W-1:0] st_rd;
  logic [NUM_SRC-1:0]          stall_src;
  logic [NUM_SRC-1:0]          fwd_load_unused;
  logic [15:0]                 count_q;

  assign ex_valid = ex_regwrite & ~flush & (ex_rd != REG_ADDR_W'(ZERO_REG));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sh_valid <= '0;
      sh_rd    <= '0;
      sh_load  <= '0;
    end else if (!hold) begin
      sh_valid[0]            <= ex_valid;
      sh_rd[0 +: REG_ADDR_W] <= ex_rd;
      sh_load[0]             <= ex_memread;
      for (int k = 1; k < DEPTH; k++) begin
        sh_valid[k]                     <= sh_valid[k-1];
        sh_rd[k*REG_ADDR_W +: REG_ADDR_W] <= sh_rd[(k-1)*REG_ADDR_W +: REG_ADDR_W];
        sh_load[k]                      <= sh_load[k-1];
      end
    end
  end

  // Stall candidates: position 0 is the live EX instruction, then entries 1..DEPTH-1
  always_comb begin
    st_valid               = '0;
    st_rd                  = '0;
    st_load                = '0;
    st_valid[0]            = ex_valid;
    st_rd[0 +: REG_ADDR_W] = ex_rd;
    st_load[0]             = ex_memread;
    for (int j = 1; j < DEPTH; j++) begin
      st_valid[j]                       = sh_valid[j-1];
      st_rd[j*REG_ADDR_W +: REG_ADDR_W] = sh_rd[(j-1)*REG_ADDR_W +: REG_ADDR_W];
      st_load[j]                        = sh_load[j-1];
    end
  end

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    logic [SEL_W-1:0] st_sel;
    logic             st_sel_load;

    fwd_match #(.W(REG_ADDR_W), .N(DEPTH), .ZERO_REG(ZERO_REG), .SEL_W(SEL_W)) u_fwd (
      .valid    (sh_valid),
      .rd       (sh_rd),
      .load     (sh_load),
      .key      (ex_src[s*REG_ADDR_W +: REG_ADDR_W]),
      .sel      (fwd_sel[s*SEL_W +: SEL_W]),
      .sel_load (fwd_load_unused[s])
    );

    fwd_match #(.W(REG_ADDR_W), .N(DEPTH), .ZERO_REG(ZERO_REG), .SEL_W(SEL_W)) u_stall (
      .valid    (st_valid),
      .rd       (st_rd),
      .load     (st_load),
      .key      (id_src[s*REG_ADDR_W +: REG_ADDR_W]),
      .sel      (st_sel),
      .sel_load (st_sel_load)
    );

    // st_sel is position+1, so position < LOAD_LAT means st_sel in 1..LOAD_LAT
    assign stall_src[s] = id_src_used[s] & st_sel_load &
                          (st_sel != SEL_W'(FWD_REGFILE)) & (st_sel <= SEL_W'(LOAD_LAT));
  end

  assign stall = reset_n & ~flush & (|stall_src);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (stall && !hold && (count_q != 16'hFFFF)) begin
      count_q <= count_q + 16'd1;
    end
  end

  assign stall_count = count_q;
endmodule

// File: tb/tb_hazard_forward_unit.sv
// tb/tb_hazard_forward_unit.sv - directed and random checks of hazard_forward_unit against a queue model
module tb_hazard_forward_unit;
  localparam int W  = 5;
  localparam int NS = 2;
  localparam int D  = 2;
  localparam int LL = 1;
  localparam int SW = 2;

  logic            clk;
  logic            reset_n;
  logic [W-1:0]    ex_rd;
  logic            ex_regwrite;
  logic            ex_memread;
  logic [NS*W-1:0] ex_src;
  logic [NS*W-1:0] id_src;
  logic [NS-1:0]   id_src_used;
  logic            hold;
  logic            flush;
  logic [NS*SW-1:0] fwd_sel;
  logic            stall;
  logic [15:0]     stall_count;

  int checks = 0;
  int errors = 0;

  // Reference state: entry k (1 = nearest EX) as plain arrays
  bit m_valid [1:D];
  int m_rd    [1:D];
  bit m_load  [1:D];
  int m_cnt;

  int s_fwd0, s_fwd1, s_stall, s_cnt;

  hazard_forward_unit #(
    .REG_ADDR_W(W), .ZERO_REG(31), .NUM_SRC(NS), .DEPTH(D), .LOAD_LAT(LL), .SEL_W(SW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
    .ex_memread(ex_memread), .ex_src(ex_src), .id_src(id_src), .id_src_used(id_src_used),
    .hold(hold), .flush(flush), .fwd_sel(fwd_sel), .stall(stall), .stall_count(stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit live_valid();
    return ex_regwrite && !flush && (int'(ex_rd) != 31);
  endfunction

  function automatic int m_fwd(input int src);
    if (src == 31) return 0;
    for (int k = 1; k <= D; k++)
      if (m_valid[k] && m_rd[k] == src) return k;
    return 0;
  endfunction

  function automatic bit m_stall();
    if (!reset_n || flush) return 0;
    for (int s = 0; s < NS; s++) begin
      int src;
      src = int'(id_src[s*W +: W]);
      if (id_src_used[s] && src != 31) begin
        for (int p = 0; p < D; p++) begin
          bit hit, ld;
          if (p == 0) begin
            hit = live_valid() && int'(ex_rd) == src;
            ld  = ex_memread;
          end else begin
            hit = m_valid[p] && m_rd[p] == src;
            ld  = m_load[p];
          end
          if (hit) begin
            if (ld && p < LL) return 1;
            break;
          end
        end
      end
    end
    return 0;
  endfunction

  task automatic m_reset();
    for (int k = 1; k <= D; k++) begin
      m_valid[k] = 0; m_rd[k] = 0; m_load[k] = 0;
    end
    m_cnt = 0;
  endtask

  task automatic step(input int rd, input bit rw, input bit mr, input int s0, input int s1,
                      input int i0, input int i1, input bit [1:0] used, input bit h, input bit f);
    bit st;
    ex_rd = W'(rd); ex_regwrite = rw; ex_memread = mr;
    ex_src = {W'(s1), W'(s0)}; id_src = {W'(i1), W'(i0)};
    id_src_used = used; hold = h; flush = f;
    #2;
    s_fwd0 = int'(fwd_sel[0 +: SW]); s_fwd1 = int'(fwd_sel[SW +: SW]);
    s_stall = int'(stall); s_cnt = int'(stall_count);
    st = m_stall();
    chk("fwd0", s_fwd0, m_fwd(s0));
    chk("fwd1", s_fwd1, m_fwd(s1));
    chk("stall", s_stall, int'(st));
    chk("count", s_cnt, m_cnt);
    @(posedge clk);
    #1;
    if (!h) begin
      if (st && m_cnt < 65535) m_cnt++;
      for (int k = D; k >= 2; k--) begin
        m_valid[k] = m_valid[k-1]; m_rd[k] = m_rd[k-1]; m_load[k] = m_load[k-1];
      end
      m_valid[1] = (rw && !f && rd != 31); m_rd[1] = rd; m_load[1] = mr;
    end
    @(negedge clk);
  endtask

  initial begin
    int regs [4] = '{1, 2, 3, 31};
    int c_a;

    // Reset state with a load-use pattern present: everything must stay quiet
    reset_n = 1'b0;
    ex_rd = 5'd2; ex_regwrite = 1'b1; ex_memread = 1'b1;
    ex_src = {5'd2, 5'd2}; id_src = {5'd2, 5'd2}; id_src_used = 2'b11;
    hold = 1'b0; flush = 1'b0;
    m_reset();
    #2;
    chk("rst_fwd", int'(fwd_sel), 0);
    chk("rst_stall", int'(stall), 0);
    chk("rst_count", int'(stall_count), 0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Youngest producer wins: ADD X1 in entry 1 over LDUR X1 in entry 2
    step(1, 1, 1, 0, 0, 0, 0, 2'b00, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    step(0, 0, 0, 1, 1, 0, 0, 2'b00, 0, 0);
    chk("prio_fwd0", s_fwd0, 1);

    // XZR never forwards and never stalls
    step(31, 1, 1, 0, 0, 31, 31, 2'b11, 0, 0);
    chk("zr_stall0", s_stall, 0);
    step(0, 0, 0, 31, 31, 31, 31, 2'b11, 0, 0);
    chk("zr_fwd0", s_fwd0, 0);
    chk("zr_stall1", s_stall, 0);

    // Asynchronous reset mid-run with a hazard presented
    step(2, 1, 1, 0, 0, 0, 0, 2'b00, 0, 0);
    ex_rd = 5'd2; ex_regwrite = 1'b1; ex_memread = 1'b1;
    ex_src = {5'd2, 5'd2}; id_src = {5'd2, 5'd2}; id_src_used = 2'b11;
    reset_n = 1'b0;
    m_reset();
    #1;
    chk("mrst_fwd", int'(fwd_sel), 0);
    chk("mrst_stall", int'(stall), 0);
    chk("mrst_count", int'(stall_count), 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Load-use: one stall, then forwarding from entry 2
    step(2, 1, 1, 0, 0, 0, 2, 2'b10, 0, 0);
    chk("lu_stall", s_stall, 1);
    step(0, 0, 0, 0, 0, 0, 2, 2'b10, 0, 0);
    chk("lu_nostall", s_stall, 0);
    chk("lu_count", s_cnt, 1);
    step(0, 0, 0, 0, 2, 0, 0, 2'b00, 0, 0);
    chk("lu_fwd1", s_fwd1, 2);

    // Unused source slot does not stall
    step(2, 1, 1, 0, 0, 5, 2, 2'b01, 0, 0);
    chk("unused_stall", s_stall, 0);

    // Flush kills both the stall and the shadow entry
    step(3, 1, 1, 0, 0, 3, 3, 2'b11, 0, 1);
    chk("flush_stall", s_stall, 0);
    step(0, 0, 0, 3, 3, 0, 0, 2'b00, 0, 0);
    chk("flush_fwd0", s_fwd0, 0);

    // Hold during a stall freezes counter and shadow
    step(4, 1, 1, 0, 0, 4, 0, 2'b01, 0, 0);
    c_a = s_cnt;
    chk("hold_stall_a", s_stall, 1);
    for (int i = 0; i < 3; i++) begin
      step(4, 1, 1, 0, 0, 4, 0, 2'b01, 1, 0);
      chk("hold_stall", s_stall, 1);
      chk("hold_count", s_cnt, c_a + 1);
    end
    step(4, 1, 1, 0, 0, 4, 0, 2'b01, 0, 0);
    chk("hold_release_count", s_cnt, c_a + 1);
    step(0, 0, 0, 4, 0, 0, 0, 2'b00, 0, 0);
    chk("hold_fwd0", s_fwd0, 1);
    chk("hold_release_count2", s_cnt, c_a + 2);

    // Saturation of the stall counter
    for (int i = 0; i < 65540; i++)
      step(5, 1, 1, 0, 0, 5, 5, 2'b11, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    chk("sat_count", s_cnt, 65535);

    // Random traffic against the model
    for (int i = 0; i < 500; i++) begin
      step(regs[$urandom_range(3)], 1'($urandom), 1'($urandom),
           regs[$urandom_range(3)], regs[$urandom_range(3)],
           regs[$urandom_range(3)], regs[$urandom_range(3)],
           2'($urandom), ($urandom_range(7) == 0), ($urandom_range(7) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/hazard_forward_unit.md
# hazard_forward_unit

Parametrised forwarding and load-use hazard unit for the pipelined LEGv8 core, and successor to the fixed two-stage forwarding logic. It tracks in-flight destination registers in an internal shadow pipeline of DEPTH stages downstream of EX. From that pipeline it:
- drives per-source forward selects for NUM_SRC execute-stage operands, giving the youngest producer priority;
- raises a load-use stall for the decode stage;
- counts stall cycles.

## Interface
Parameters:
- REG_ADDR_W, 5, register address width
- ZERO_REG, 31, register index that is never forwarded (XZR)
- NUM_SRC, 2, number of source operands per instruction (channels)
- DEPTH, 2, shadow stages after EX (2 = EX/MEM, MEM/WB)
- LOAD_LAT, 1, stages after EX before load data is forwardable; legal range 0 ≤ LOAD_LAT < DEPTH
- SEL_W, $clog2(DEPTH+1), width of one forward select

Ports:
- clk, input, 1, core clock, rising edge
- reset_n, input, 1, asynchronous active-low reset
- ex_rd, input, REG_ADDR_W, destination of the instruction in EX
- ex_regwrite, input, 1, EX instruction writes a register
- ex_memread, input, 1, EX instruction is a load
- ex_src, input, NUM_SRC*REG_ADDR_W, EX source addresses; slot 0 is Rn, slot 1 is Rm
- id_src, input, NUM_SRC*REG_ADDR_W, ID source addresses
- id_src_used, input, NUM_SRC, per-slot flag: the ID source is actually read
- hold, input, 1, global pipeline freeze (memory wait)
- flush, input, 1, the EX instruction is squashed this cycle
- fwd_sel, output, NUM_SRC*SEL_W, per-source select: 0 = register file, k = shadow stage k (1 = nearest EX)
- stall, output, 1, hold PC and IF/ID, insert a bubble into ID/EX
- stall_count, output, 16, saturating count of stall cycles

## Operation
- Shadow entry k (1..DEPTH) holds {valid, rd, load}.
- Each clock edge with hold=0:
  - entry 1 ← {ex_regwrite & ~flush & (ex_rd≠ZERO_REG), ex_rd, ex_memread};
  - entry k ← entry k-1 for k ≥ 2;
  - the oldest entry is discarded.
- Each clock edge with hold=1: all entries keep their values.
- Forwarding, per source s:
  - fwd_sel[s] is the smallest k such that entry k is valid and entry k.rd = ex_src[s];
  - fwd_sel[s] is 0 if no entry matches;
  - ex_src[s] = ZERO_REG always gives 0.
- Load-use stall. Position 0 is the live EX instruction (valid when ex_regwrite & ~flush & ex_rd≠ZERO_REG). For each used ID source:
  - find the youngest matching position j among 0..DEPTH-1;
  - stall=1 if that producer is a load and j < LOAD_LAT;
  - a younger non-load match masks an older load;
  - source ZERO_REG never stalls.
- flush=1 forces stall=0.
- stall_count:
  - increments on each edge where stall=1 and hold=0;
  - saturates at 16'hFFFF;
  - clears only on reset.
- The encoding differs from the legacy 2'b10/2'b01. The datapath mux is re-coded to 1 = EX/MEM, 2 = MEM/WB.

## Timing
- Reset (reset_n=0, asynchronous):
  - all shadow valid bits are 0;
  - stall_count is 0;
  - fwd_sel is 0;
  - stall is gated to 0 while reset_n=0.
- fwd_sel and stall are combinational from the current shadow state and inputs, valid in the same cycle. No added latency.
- A producer in EX at cycle t is forwardable through entry 1 at t+1 and through entry k at t+k (assuming hold=0).
- With LOAD_LAT=1, a load followed immediately by a dependent instruction gives exactly one stall cycle. The consumer then receives fwd_sel=2.
- hold mid-stall:
  - stall stays asserted;
  - shadow and stall_count are frozen;
  - on release, behaviour resumes as if the hold cycles never occurred.
- Reset asserted mid-operation takes effect immediately. The first edge after deassertion loads entry 1 normally.
- stall and flush in the same cycle: flush wins.

## Structure
- Shared package arm_pipe_pkg:
  - REG_ADDR_W and ZERO_REG defaults;
  - FWD_REGFILE = 0;
  - shadow entry struct {valid, rd, load}.
- Sub-module fwd_match:
  - parametrised priority encoder that returns the youngest matching index and its load flag;
  - instantiated once per EX source (forwarding) and once per ID source (stall check).
- Top level contains:
  - shadow shift register;
  - stall OR-reduction;
  - saturating counter.

## Test plan
- Forwarding priority: ADD X1 in entry 1 and an older LDUR-completed X1 in entry 2, ex_src slot 0 = X1 -> fwd_sel[0]=1, not 2.
- Zero register: ex_rd=31 with regwrite=1, next cycle ex_src=31 -> fwd_sel=0 and no stall at any point.
- Load-use: LDUR X2 in EX, id_src slot 1 = X2 used -> stall=1 for exactly 1 cycle, stall_count=1, consumer's fwd_sel[1]=2 in its EX cycle.
- Unused source: same as the load-use case with id_src_used[1]=0 -> stall=0.
- Flush: flush=1 with a load in EX and a dependent ID -> stall=0, entry 1 invalid, next-cycle fwd_sel=0.
- Hold and reset:
  - hold=1 for 3 cycles during a stall -> stall_count unchanged and shadow frozen;
  - reset_n pulsed low mid-run -> stall_count=0, fwd_sel=0, stall=0 immediately;
  - counter forced to near 16'hFFFF -> saturates at 16'hFFFF.
